dsack_port_responder: RTL and testbench
=======================================

Name: dsack_port_responder

Overview:
Amiga-side slave for 68030-style asynchronous bus cycles that uses the SIZ/A/DSACK dynamic-sizing protocol. It decodes a sized cycle aimed at a 16-bit on-card device port and generates device strobes and byte enables. It steers data between the 32-bit Amiga data bus (port on D31:16) and the device, then terminates the cycle with word-port DSACK. This is the responder end of the sizing protocol, sitting between the AmigaPCI bus buffers and on-card 16-bit resources.

Parameters:
WAIT_STATES, 2, BCLK cycles inserted between the cycle being accepted and the device strobe (0-15).
TIMEOUT_CYCLES, 255, BCLK cycles in ACCESS without DEV_ACK before bus error (optional feature only; 1-255).

Ports:
BCLK  in  1  bus clock; all logic on posedge.
nRESET  in  1  asynchronous, active-low reset.
nAS  in  1  address strobe, active low.
nDS  in  1  data strobe, active low.
nCS  in  1  decoded port select, active low.
RnW  in  1  1 = read, 0 = write.
SIZ  in  2  transfer size: 00 long, 01 byte, 10 word, 11 three-byte.
A  in  2  address bits 1:0.
DB_IN  in  32  Amiga data bus, write data.
DB_OUT  out  32  read data; D31:16 driven, D15:0 = 0.
DB_OE  out  1  read data output enable.
DSACK  out  2  active low; 11 idle, 01 word-port termination.
nBERR  out  1  bus error, active low.
DEV_STB  out  1  device access strobe.
DEV_WE  out  1  device write enable.
DEV_BE  out  2  byte enables; [1] = D31:24 / even byte, [0] = D23:16 / odd byte.
DEV_A1  out  1  latched A[1].
DEV_WDATA  out  16  write data to device.
DEV_RDATA  in  16  read data from device.
DEV_ACK  in  1  device done, sampled on posedge.

Behaviour:
- Input registering:
  - nAS, nDS and nCS are registered once (nAS_q, nDS_q, nCS_q) before use.
  - All other inputs are used directly.
- Reset values:
  - DSACK=11, nBERR=1, DB_OE=0, DB_OUT=0.
  - DEV_STB=0, DEV_WE=0, DEV_BE=00, DEV_A1=0, DEV_WDATA=0.
  - State = IDLE, wait counter = 0.
  - Reset asserted mid-cycle drops all of these immediately (asynchronous).
- States: IDLE, WAIT, ACCESS, TERM, RELEASE.
- IDLE:
  - When nAS_q=0 and nCS_q=0: latch RnW, SIZ, A; load counter = WAIT_STATES; go to WAIT.
  - nCS is qualified only in IDLE. A change of nCS later in the cycle is ignored.
- Byte enables:
  - SIZ=01 with A0=0 -> DEV_BE=10.
  - SIZ=01 with A0=1 -> DEV_BE=01.
  - Any other SIZ with A0=0 -> 11.
  - Any other SIZ with A0=1 -> 01.
  - DEV_BE is set when entering ACCESS.
- WAIT:
  - Decrement the counter while it is nonzero.
  - At counter 0, go to ACCESS only if the cycle is a read, or if it is a write and nDS_q=0.
  - On entry to ACCESS: DEV_STB=1, DEV_WE=~RnW_latched, DEV_WDATA=DB_IN[31:16].
- ACCESS:
  - Hold DEV_STB until DEV_ACK=1.
  - Then: DEV_STB=0, DEV_WE=0, capture DEV_RDATA into DB_OUT[31:16], DSACK=01, and for reads DB_OE=1. Go to TERM.
- TERM:
  - Hold DSACK and DB_OE until nAS_q=1.
  - Then DSACK=11, DB_OE=0, DEV_BE=00; go to RELEASE.
- RELEASE:
  - Unconditional return to IDLE.
  - Guarantees at least one idle cycle, so back-to-back cycles cannot re-trigger on a stale nAS_q.
- Latency, DEV_ACK tied high:
  - Count from the first posedge that samples nAS low.
  - DSACK asserts on posedge 4+WAIT_STATES.
- Abort (nAS_q=1 in WAIT or ACCESS):
  - Drop DEV_STB and DEV_WE without asserting DSACK.
  - Go to RELEASE.
  - A DEV_ACK that arrives after the abort is ignored.
- Dynamic sizing:
  - DSACK is always 01 (16-bit port).
  - The master re-runs the remaining bytes of long and three-byte transfers. The block treats each run as an independent cycle.

Optional Feature:
DSACK_TIMEOUT_EN
- Defined:
  - A counter runs from entry to ACCESS.
  - If it reaches TIMEOUT_CYCLES with no DEV_ACK: nBERR=0, DSACK stays 11, DEV_STB=0, go to TERM.
  - nBERR releases on the same edge DSACK would release.
- Undefined:
  - nBERR is tied to 1.
  - ACCESS waits indefinitely for DEV_ACK.

Test Plan:
- Word read, WAIT_STATES=2, DEV_ACK tied 1, A=00, SIZ=10, DEV_RDATA=16'hBEEF -> DEV_BE=11; DSACK=01 on posedge 6 after nAS sampled low; DB_OUT=32'hBEEF0000 with DB_OE=1; DSACK=11 one edge after nAS_q rises.
- Byte write, A=01, SIZ=01, DB_IN=32'h0012_0000, nDS low -> DEV_BE=01, DEV_WE=1, DEV_WDATA=16'h0012, DSACK=01.
- Long read, SIZ=00, A=00, followed by a second cycle with SIZ=10, A=10 -> two independent DSACK=01 terminations; DEV_A1=0 then 1; RELEASE idle cycle seen between them.
- Write with nDS held high 5 cycles past the wait count -> DEV_STB stays 0 until 1 edge after nDS_q goes low.
- nAS negated during WAIT -> no DEV_STB, DSACK stays 11, FSM reaches IDLE in 2 edges; nRESET pulsed during TERM -> DSACK=11 and DB_OE=0 immediately.
- DSACK_TIMEOUT_EN with TIMEOUT_CYCLES=8 and DEV_ACK held 0 -> nBERR=0 after 8 ACCESS cycles, DSACK=11, DEV_STB=0; both release after nAS negates.

Source files
------------

// File: rtl/dsack_port_responder.sv
// rtl/dsack_port_responder.sv - 68030 dynamic-sizing slave for a 16-bit on-card port, word-port DSACK termination
// Optional build macro DSACK_TIMEOUT_EN: bus error via nBERR when the device never acknowledges.
module dsack_port_responder #(
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        BCLK,
  input  logic        nRESET,
  input  logic        nAS,
  input  logic        nDS,
  input  logic        nCS,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [1:0]  A,
  input  logic [31:0] DB_IN,
  output logic [31:0] DB_OUT,
  output logic        DB_OE,
  output logic [1:0]  DSACK,
  output logic        nBERR,
  output logic        DEV_STB,
  output logic        DEV_WE,
  output logic [1:0]  DEV_BE,
  output logic        DEV_A1,
  output logic [15:0] DEV_WDATA,
  input  logic [15:0] DEV_RDATA,
  input  logic        DEV_ACK
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_TERM    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);

  logic [2:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        nas_q, nas_d;
  logic        nds_q, nds_d;
  logic        ncs_q, ncs_d;
  logic        rnw_q, rnw_d;
  logic [1:0]  siz_q, siz_d;
  logic        a0_q, a0_d;
  logic [1:0]  dsack_q, dsack_d;
  logic        db_oe_q, db_oe_d;
  logic [15:0] db_out_q, db_out_d;
  logic        dev_stb_q, dev_stb_d;
  logic        dev_we_q, dev_we_d;
  logic [1:0]  dev_be_q, dev_be_d;
  logic        dev_a1_q, dev_a1_d;
  logic [15:0] dev_wdata_q, dev_wdata_d;
  logic [1:0]  be_sel;
  logic        unused_bits;

`ifdef DSACK_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        nberr_q, nberr_d;
  assign nBERR       = nberr_q;
  assign unused_bits = ^DB_IN[15:0];
`else
  assign nBERR       = 1'b1;
  assign unused_bits = ^{DB_IN[15:0], 8'(TIMEOUT_CYCLES)};
`endif

  // Byte lanes on the D31:16 port: a single byte picks its lane from A0,
  // wider sizes cover both lanes unless they start on the odd byte.
  always_comb begin
    be_sel = 2'b11;
    if (siz_q == 2'b01) begin
      be_sel = a0_q ? 2'b01 : 2'b10;
    end else begin
      be_sel = a0_q ? 2'b01 : 2'b11;
    end
  end

  always_comb begin
    nas_d       = nAS;
    nds_d       = nDS;
    ncs_d       = nCS;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rnw_d       = rnw_q;
    siz_d       = siz_q;
    a0_d        = a0_q;
    dsack_d     = dsack_q;
    db_oe_d     = db_oe_q;
    db_out_d    = db_out_q;
    dev_stb_d   = dev_stb_q;
    dev_we_d    = dev_we_q;
    dev_be_d    = dev_be_q;
    dev_a1_d    = dev_a1_q;
    dev_wdata_d = dev_wdata_q;
`ifdef DSACK_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    nberr_d     = nberr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // nCS is only qualified here; later changes within the cycle do not matter.
        if (!nas_q && !ncs_q) begin
          rnw_d      = RnW;
          siz_d      = SIZ;
          a0_d       = A[0];
          dev_a1_d   = A[1];
          wait_cnt_d = WAIT_LOAD;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (nas_q) begin
          dev_stb_d = 1'b0;
          dev_we_d  = 1'b0;
          dev_be_d  = 2'b00;
          state_d   = ST_RELEASE;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else if (rnw_q || !nds_q) begin
          dev_stb_d   = 1'b1;
          dev_we_d    = ~rnw_q;
          dev_wdata_d = DB_IN[31:16];
          dev_be_d    = be_sel;
`ifdef DSACK_TIMEOUT_EN
          to_cnt_d    = 8'd0;
`endif
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (nas_q) begin
          dev_stb_d = 1'b0;
          dev_we_d  = 1'b0;
          dev_be_d  = 2'b00;
          state_d   = ST_RELEASE;
        end else if (DEV_ACK) begin
          dev_stb_d = 1'b0;
          dev_we_d  = 1'b0;
          db_out_d  = DEV_RDATA;
          dsack_d   = 2'b01;
          db_oe_d   = rnw_q;
          state_d   = ST_TERM;
        end
`ifdef DSACK_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          dev_stb_d = 1'b0;
          dev_we_d  = 1'b0;
          nberr_d   = 1'b0;
          state_d   = ST_TERM;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end

      ST_TERM: begin
        if (nas_q) begin
          dsack_d  = 2'b11;
          db_oe_d  = 1'b0;
          dev_be_d = 2'b00;
`ifdef DSACK_TIMEOUT_EN
          nberr_d  = 1'b1;
`endif
          state_d  = ST_RELEASE;
        end
      end

      // One guaranteed idle cycle so a stale nas_q cannot start a new cycle.
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      nas_q       <= 1'b1;
      nds_q       <= 1'b1;
      ncs_q       <= 1'b1;
      rnw_q       <= 1'b1;
      siz_q       <= 2'b00;
      a0_q        <= 1'b0;
      dsack_q     <= 2'b11;
      db_oe_q     <= 1'b0;
      db_out_q    <= 16'h0000;
      dev_stb_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_be_q    <= 2'b00;
      dev_a1_q    <= 1'b0;
      dev_wdata_q <= 16'h0000;
`ifdef DSACK_TIMEOUT_EN
      to_cnt_q    <= 8'd0;
      nberr_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      nas_q       <= nas_d;
      nds_q       <= nds_d;
      ncs_q       <= ncs_d;
      rnw_q       <= rnw_d;
      siz_q       <= siz_d;
      a0_q        <= a0_d;
      dsack_q     <= dsack_d;
      db_oe_q     <= db_oe_d;
      db_out_q    <= db_out_d;
      dev_stb_q   <= dev_stb_d;
      dev_we_q    <= dev_we_d;
      dev_be_q    <= dev_be_d;
      dev_a1_q    <= dev_a1_d;
      dev_wdata_q <= dev_wdata_d;
`ifdef DSACK_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      nberr_q     <= nberr_d;
`endif
    end
  end

  assign DSACK     = dsack_q;
  assign DB_OE     = db_oe_q;
  assign DB_OUT    = {db_out_q, 16'h0000};
  assign DEV_STB   = dev_stb_q;
  assign DEV_WE    = dev_we_q;
  assign DEV_BE    = dev_be_q;
  assign DEV_A1    = dev_a1_q;
  assign DEV_WDATA = dev_wdata_q;

endmodule

// File: tb/tb_dsack_port_responder.sv
// tb/tb_dsack_port_responder.sv - self-checking bench for dsack_port_responder
module tb_dsack_port_responder;

  localparam int WS = 2;
  localparam int TO = 8;

  logic        BCLK = 1'b0;
  logic        nRESET;
  logic        nAS, nDS, nCS, RnW;
  logic [1:0]  SIZ, A;
  logic [31:0] DB_IN;
  logic [31:0] DB_OUT;
  logic        DB_OE;
  logic [1:0]  DSACK;
  logic        nBERR;
  logic        DEV_STB, DEV_WE;
  logic [1:0]  DEV_BE;
  logic        DEV_A1;
  logic [15:0] DEV_WDATA;
  logic [15:0] DEV_RDATA;
  logic        DEV_ACK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rnw;
    logic [1:0]  siz;
    logic [1:0]  a;
    logic [31:0] db_in;
    logic [15:0] rdata;
    logic [1:0]  be;
    logic        a1;
    logic        we;
    logic [15:0] wdata;
    logic [31:0] db_out;
    logic        oe;
  } vec_t;

  vec_t vecs[8];
  vec_t sbq[$];

  dsack_port_responder #(.WAIT_STATES(WS), .TIMEOUT_CYCLES(TO)) dut (
    .BCLK(BCLK), .nRESET(nRESET), .nAS(nAS), .nDS(nDS), .nCS(nCS), .RnW(RnW),
    .SIZ(SIZ), .A(A), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .DSACK(DSACK), .nBERR(nBERR), .DEV_STB(DEV_STB), .DEV_WE(DEV_WE),
    .DEV_BE(DEV_BE), .DEV_A1(DEV_A1), .DEV_WDATA(DEV_WDATA),
    .DEV_RDATA(DEV_RDATA), .DEV_ACK(DEV_ACK)
  );

  always #5 BCLK = ~BCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge BCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    nAS = 1'b1;
    nDS = 1'b1;
    nCS = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   n;
    bit   seen_stb;
    RnW       = v.rnw;
    SIZ       = v.siz;
    A         = v.a;
    DB_IN     = v.db_in;
    DEV_RDATA = v.rdata;
    nCS       = 1'b0;
    nAS       = 1'b0;
    nDS       = 1'b0;
    sbq.push_back(v);
    n        = 0;
    seen_stb = 0;
    while (DSACK !== 2'b01 && n < 40) begin
      tick();
      n++;
      if (DEV_STB === 1'b1 && !seen_stb) begin
        seen_stb = 1;
        e = sbq[0];
        chk("stb_edge", n, 3 + WS);
        chk("dev_be", DEV_BE, e.be);
        chk("dev_we", DEV_WE, e.we);
        chk("dev_a1", DEV_A1, e.a1);
        if (!e.rnw) chk("dev_wdata", DEV_WDATA, e.wdata);
      end
    end
    chk("stb_seen", seen_stb, 1);
    chk("sb_nonempty", sbq.size(), 1);
    e = sbq.pop_front();
    chk("dsack_latency", n, 4 + WS);
    chk("dsack_term", DSACK, 2'b01);
    chk("db_oe", DB_OE, e.oe);
    if (e.rnw) chk("db_out", DB_OUT, e.db_out);
    bus_idle();
    tick();
    chk("dsack_hold", DSACK, 2'b01);
    tick();
    chk("dsack_release", DSACK, 2'b11);
    chk("db_oe_release", DB_OE, 1'b0);
  endtask

  initial begin
    bit bad;
    int n;

    //          rnw   siz    a      db_in          rdata     be     a1    we    wdata     db_out         oe
    vecs[0] = '{1'b1, 2'b10, 2'b00, 32'h0000_0000, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000, 32'hBEEF_0000, 1'b1};
    vecs[1] = '{1'b0, 2'b01, 2'b01, 32'h0012_0000, 16'h0000, 2'b01, 1'b0, 1'b1, 16'h0012, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 2'b00, 2'b00, 32'h0000_0000, 16'h1234, 2'b11, 1'b0, 1'b0, 16'h0000, 32'h1234_0000, 1'b1};
    vecs[3] = '{1'b1, 2'b10, 2'b10, 32'h0000_0000, 16'h5678, 2'b11, 1'b1, 1'b0, 16'h0000, 32'h5678_0000, 1'b1};
    vecs[4] = '{1'b0, 2'b01, 2'b00, 32'hAB00_0000, 16'h0000, 2'b10, 1'b0, 1'b1, 16'hAB00, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 2'b11, 2'b01, 32'h00CD_EF00, 16'h0000, 2'b01, 1'b0, 1'b1, 16'h00CD, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 2'b11, 32'h0000_0000, 16'h00C3, 2'b01, 1'b1, 1'b0, 16'h0000, 32'h00C3_0000, 1'b1};
    vecs[7] = '{1'b0, 2'b10, 2'b10, 32'h7788_0000, 16'h0000, 2'b11, 1'b1, 1'b1, 16'h7788, 32'h0000_0000, 1'b0};

    nRESET = 1'b0;
    bus_idle();
    RnW = 1'b1; SIZ = 2'b00; A = 2'b00; DB_IN = 32'h0; DEV_RDATA = 16'h0; DEV_ACK = 1'b1;
    tick();
    tick();
    chk("rst_dsack", DSACK, 2'b11);
    chk("rst_nberr", nBERR, 1'b1);
    chk("rst_db_oe", DB_OE, 1'b0);
    chk("rst_db_out", DB_OUT, 32'h0);
    chk("rst_dev_stb", DEV_STB, 1'b0);
    chk("rst_dev_we", DEV_WE, 1'b0);
    chk("rst_dev_be", DEV_BE, 2'b00);
    chk("rst_dev_a1", DEV_A1, 1'b0);
    chk("rst_dev_wdata", DEV_WDATA, 16'h0);
    nRESET = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Write held off by nDS well past the wait count.
    RnW = 1'b0; SIZ = 2'b10; A = 2'b00; DB_IN = 32'h5A5A_0000;
    nCS = 1'b0; nAS = 1'b0; nDS = 1'b1;
    bad = 0;
    for (int i = 0; i < 5 + WS + 3; i++) begin
      tick();
      if (DEV_STB !== 1'b0) bad = 1;
    end
    chk("nds_hold_stb", bad, 0);
    nDS = 1'b0;
    tick();
    chk("nds_q_edge_stb", DEV_STB, 1'b0);
    tick();
    chk("nds_access_stb", DEV_STB, 1'b1);
    chk("nds_access_we", DEV_WE, 1'b1);
    chk("nds_access_wdata", DEV_WDATA, 16'h5A5A);
    tick();
    chk("nds_dsack", DSACK, 2'b01);
    bus_idle();
    tick();
    tick();
    chk("nds_dsack_release", DSACK, 2'b11);

    // Abort during WAIT: nothing reaches the device, then a clean cycle follows.
    RnW = 1'b1; SIZ = 2'b10; A = 2'b00;
    nCS = 1'b0; nAS = 1'b0; nDS = 1'b0;
    tick();
    tick();
    bus_idle();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (DEV_STB !== 1'b0 || DSACK !== 2'b11) bad = 1;
    end
    chk("abort_wait_quiet", bad, 0);
    run_vec(vecs[3]);

    // Asynchronous reset while holding DSACK in TERM.
    RnW = 1'b1; SIZ = 2'b10; A = 2'b00; DEV_RDATA = 16'hCAFE;
    nCS = 1'b0; nAS = 1'b0; nDS = 1'b0;
    n = 0;
    while (DSACK !== 2'b01 && n < 40) begin
      tick();
      n++;
    end
    chk("term_reached", DSACK, 2'b01);
    chk("term_db_oe", DB_OE, 1'b1);
    nRESET = 1'b0;
    #1;
    chk("async_rst_dsack", DSACK, 2'b11);
    chk("async_rst_db_oe", DB_OE, 1'b0);
    chk("async_rst_db_out", DB_OUT, 32'h0);
    chk("async_rst_dev_be", DEV_BE, 2'b00);
    bus_idle();
    tick();
    nRESET = 1'b1;
    tick();
    tick();

    // Device never acknowledges.
    DEV_ACK = 1'b0;
    RnW = 1'b1; SIZ = 2'b10; A = 2'b00;
    nCS = 1'b0; nAS = 1'b0; nDS = 1'b0;
    for (int i = 0; i < 3 + WS; i++) tick();
    chk("hang_stb", DEV_STB, 1'b1);
`ifdef DSACK_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_pre_nberr", nBERR, 1'b1);
    chk("to_pre_stb", DEV_STB, 1'b1);
    tick();
    chk("to_nberr", nBERR, 1'b0);
    chk("to_dsack", DSACK, 2'b11);
    chk("to_stb", DEV_STB, 1'b0);
    bus_idle();
    tick();
    chk("to_nberr_hold", nBERR, 1'b0);
    tick();
    chk("to_nberr_release", nBERR, 1'b1);
    chk("to_dsack_release", DSACK, 2'b11);
`else
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DEV_STB !== 1'b1 || nBERR !== 1'b1 || DSACK !== 2'b11) bad = 1;
    end
    chk("hang_waits", bad, 0);
    bus_idle();
    tick();
    chk("abort_access_stb_hold", DEV_STB, 1'b1);
    tick();
    chk("abort_access_stb", DEV_STB, 1'b0);
    chk("abort_access_dsack", DSACK, 2'b11);
    DEV_ACK = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (DSACK !== 2'b11 || DB_OE !== 1'b0) bad = 1;
    end
    chk("late_ack_ignored", bad, 0);
`endif
    DEV_ACK = 1'b1;
    bus_idle();
    tick();
    tick();
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
